// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 16-bit carry-select adder
// between NREQ requesters. Fully pipelined: one grant and one tagged result
// per cycle, with a fixed latency of two cycles from gnt to rsp_valid.
//
// Ports
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   req        per-requester add request
//   req_a      operand A of requester i at [16*i +: 16]
//   req_b      operand B of requester i at [16*i +: 16]
//   gnt        one-hot grant (combinational); operands captured at this edge
//   rsp_valid  one-hot response tag, valid for exactly one cycle per grant
//   rsp_sum    registered 16-bit sum, holds last result when idle
//   rsp_co     registered unsigned carry-out of the last add
module adder_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_sum,
  output logic                 rsp_co
);

  localparam int unsigned DW   = 16;
  localparam int unsigned BW   = 4;
  localparam int unsigned NBLK = DW / BW;

  logic [DW-1:0]  a_arr [NREQ];
  logic [DW-1:0]  b_arr [NREQ];
  logic [IDW-1:0] ptr;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           s1_vld;
  logic [IDW-1:0] s1_id;
  logic [DW-1:0]  s1_a;
  logic [DW-1:0]  s1_b;
  logic [DW-1:0]  csa_sum;
  logic           csa_co;

  // Unpack the flat operand buses so the granted slot can be selected by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[DW*g +: DW];
    assign b_arr[g] = req_b[DW*g +: DW];
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!gnt_any && req[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Grant decode; masked during reset so no requester believes it was served.
  always_comb begin
    gnt = '0;
    if (gnt_any && Reset_n) gnt[gnt_idx] = 1'b1;
  end

  // Carry-select adder: each 4-bit block precomputes both carry-in cases,
  // the ripple only travels through the selection muxes.
  always_comb begin
    logic       c;
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;
    c       = 1'b0;
    sum_c0  = '0;
    sum_c1  = '0;
    csa_sum = '0;
    for (int unsigned g = 0; g < NBLK; g++) begin
      sum_c0 = {1'b0, s1_a[BW*g +: BW]} + {1'b0, s1_b[BW*g +: BW]};
      sum_c1 = sum_c0 + 5'd1;
      csa_sum[BW*g +: BW] = c ? sum_c1[BW-1:0] : sum_c0[BW-1:0];
      c = c ? sum_c1[BW] : sum_c0[BW];
    end
    csa_co = c;
  end

  // Stage 1 captures the granted operands; stage 2 (rsp_*) registers the
  // sum and the one-hot tag directly, so rsp_valid is the stage-2 valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr       <= IDW'(NREQ - 1);
      s1_vld    <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        ptr   <= gnt_idx;
        s1_id <= gnt_idx;
        s1_a  <= a_arr[gnt_idx];
        s1_b  <= b_arr[gnt_idx];
      end
      rsp_valid <= s1_vld ? (NREQ'(1) << s1_id) : '0;
      if (s1_vld) begin
        rsp_sum <= csa_sum;
        rsp_co  <= csa_co;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors for adder_arbiter with a scoreboard.
// The stimulus process checks gnt and queues the hand-computed response;
// a monitor pops and compares whenever rsp_valid fires (or a response is due).
module tb_adder_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  req;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [2:0]  gnt;
  logic [2:0]  rsp_valid;
  logic [15:0] rsp_sum;
  logic        rsp_co;

  typedef struct {
    logic [2:0]  vld;
    logic [15:0] sum;
    logic        co;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  adder_arbiter #(.NREQ(3), .IDW(2)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One arbitration cycle: drive after the edge, check gnt mid-cycle,
  // and queue the expected response when one should follow.
  task automatic step(input logic [2:0] r,
                      input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input logic [15:0] a2, input logic [15:0] b2,
                      input logic [2:0] eg, input logic [15:0] es,
                      input logic ec, input bit push);
    exp_t e;
    @(posedge Clk);
    #1;
    req   = r;
    req_a = {a2, a1, a0};
    req_b = {b2, b1, b0};
    @(negedge Clk);
    chk("gnt", 32'(gnt), 32'(eg));
    if (push && eg != 3'b000) begin
      e.vld = eg;
      e.sum = es;
      e.co  = ec;
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 3'b000, 16'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every response must match the queue head on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (rsp_valid != 3'b000) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_co", 32'(rsp_co), 32'(e.co));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'(e.vld));
      end
    end
  end

  initial begin
    logic [2:0]  rr_gnt [3];
    logic [15:0] rr_sum [3];
    rr_gnt[0] = 3'b001; rr_gnt[1] = 3'b010; rr_gnt[2] = 3'b100;
    rr_sum[0] = 16'h0010; rr_sum[1] = 16'h0011; rr_sum[2] = 16'h0012;

    // Reset with all requesting: nothing granted, outputs cleared.
    Reset_n = 1'b0;
    req     = 3'b111;
    req_a   = {16'h0003, 16'h0002, 16'h0001};
    req_b   = {16'h0003, 16'h0002, 16'h0001};
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    chk("rst_rsp_co", 32'(rsp_co), 32'h0);
    req     = 3'b000;
    Reset_n = 1'b1;

    // Single add from requester 0.
    step(3'b001, 16'h1234, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 3'b001, 16'h1235, 1'b0, 1'b1);
    idle(3);

    // Carry-out cases on requester 1, then a carry across block boundaries.
    step(3'b010, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 3'b010, 16'h0000, 1'b1, 1'b1);
    step(3'b010, 16'h0, 16'h0, 16'h8000, 16'h8000, 16'h0, 16'h0, 3'b010, 16'h0000, 1'b1, 1'b1);
    step(3'b100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0FFF, 16'h0001, 3'b100, 16'h1000, 1'b0, 1'b1);
    idle(2);

    // All requesting for six cycles: strict rotation, back-to-back results.
    for (int i = 0; i < 6; i++)
      step(3'b111, 16'h0000, 16'h0010, 16'h0001, 16'h0010, 16'h0002, 16'h0010,
           rr_gnt[i % 3], rr_sum[i % 3], 1'b0, 1'b1);
    idle(2);

    // Last winner 1, then 0 and 2 requesting: 2 first, then wrap to 0.
    step(3'b010, 16'h0, 16'h0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 3'b010, 16'h8000, 1'b0, 1'b1);
    step(3'b101, 16'hAAAA, 16'h5555, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 3'b100, 16'hFFFE, 1'b1, 1'b1);
    step(3'b101, 16'hAAAA, 16'h5555, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 3'b001, 16'hFFFF, 1'b0, 1'b1);
    idle(4);

    // Three back-to-back grants; reset mid-cycle after the first response.
    step(3'b001, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 3'b001, 16'h0003, 1'b0, 1'b1);
    step(3'b010, 16'h0, 16'h0, 16'h0005, 16'h0005, 16'h0, 16'h0, 3'b010, 16'h0, 1'b0, 1'b0);
    step(3'b100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0007, 16'h0007, 3'b100, 16'h0, 1'b0, 1'b0);
    #1;
    Reset_n = 1'b0;
    req     = 3'b111;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_rsp_sum", 32'(rsp_sum), 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_gnt_held", 32'(gnt), 32'h0);
    req     = 3'b000;
    Reset_n = 1'b1;
    idle(2);

    // After reset, arbitration restarts from requester 0.
    step(3'b111, 16'h4000, 16'h4000, 16'h1111, 16'h1111, 16'h2222, 16'h2222, 3'b001, 16'h8000, 1'b0, 1'b1);
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
